// File: rtl/tick_timer_arbiter.sv
// tick_timer_arbiter: round-robin shared interval counter with one-cycle done pulse to the owner.
module tick_timer_arbiter #(
  parameter int NREQ = 4,
  parameter int N    = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            tick,
  input  logic            abort,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ*N-1:0] dur,
  output logic [NREQ-1:0] gnt,
  output logic [NREQ-1:0] done,
  output logic            busy,
  output logic [N-1:0]    count_out
);
  localparam int IW = $clog2(NREQ);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] last_q, last_d, win;
  logic found;
  logic [N-1:0] count_q, count_d, max_q, max_d;
  logic [NREQ-1:0] gnt_q, gnt_d, done_q, done_d;
  logic at_max;
  assign at_max = (count_q == max_q);
  // last_q doubles as the owner index while a timing is in progress
  always_comb begin : arb
    int k;
    win = last_q;
    found = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      k = int'(last_q) + i;
      if (k >= NREQ) k = k - NREQ;
      if (!found && req[k]) begin
        found = 1'b1;
        win = IW'(k);
      end
    end
  end
  always_comb begin
    state_d = state_q;
    last_d = last_q;
    count_d = count_q;
    max_d = max_q;
    gnt_d = gnt_q;
    done_d = '0;
    case (state_q)
      IDLE: if (found) begin
        state_d = RUN;
        max_d = dur[int'(win)*N +: N];
        count_d = '0;
        last_d = win;
        gnt_d = '0;
        gnt_d[win] = 1'b1;
      end
      RUN: if (abort || !req[last_q]) begin
        state_d = IDLE;
        gnt_d = '0;
        count_d = '0;
      end else if (at_max) begin
        state_d = DONE;
        done_d = gnt_q;
      end else begin
        count_d = count_q + {{(N-1){1'b0}}, tick};
      end
      default: begin
        state_d = IDLE;
        gnt_d = '0;
        count_d = '0;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q <= IW'(NREQ - 1);
      count_q <= '0;
      max_q <= '0;
      gnt_q <= '0;
      done_q <= '0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      count_q <= count_d;
      max_q <= max_d;
      gnt_q <= gnt_d;
      done_q <= done_d;
    end
  end
  assign gnt = gnt_q;
  assign done = done_q;
  assign busy = (state_q != IDLE);
  assign count_out = count_q;
endmodule

// File: tb/tb_tick_timer_arbiter.sv
// tb_tick_timer_arbiter: directed stimulus with grant/done scoreboard queues checked by a negedge monitor.
module tb_tick_timer_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick = 1'b0;
  logic abort = 1'b0;
  logic [3:0] req = '0;
  logic [31:0] dur = '0;
  logic [3:0] gnt, done;
  logic busy;
  logic [7:0] count_out;
  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  typedef struct {logic [3:0] v; int c; int cnt;} exp_t;
  exp_t dq[$];
  exp_t gq[$];
  logic [3:0] prev_gnt = '0;

  tick_timer_arbiter #(.NREQ(4), .N(8)) dut (
    .clk(clk), .rst(rst), .tick(tick), .abort(abort), .req(req), .dur(dur),
    .gnt(gnt), .done(done), .busy(busy), .count_out(count_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) step();
  endtask

  task automatic push_g(input int i, input int c);
    exp_t e;
    e.v = 4'b0001 << i;
    e.c = c;
    e.cnt = 0;
    gq.push_back(e);
  endtask

  task automatic push_d(input int i, input int c, input int cnt);
    exp_t e;
    e.v = 4'b0001 << i;
    e.c = c;
    e.cnt = cnt;
    dq.push_back(e);
  endtask

  // monitor: pops an expectation whenever a grant starts or a done pulse appears
  always @(negedge clk) begin
    exp_t e;
    if (gnt != 4'b0 && prev_gnt == 4'b0) begin
      if (gq.size() == 0) cmp("unexpected_gnt", 32'(gnt), 0);
      else begin
        e = gq.pop_front();
        cmp("gnt_value", 32'(gnt), 32'(e.v));
        cmp("gnt_cycle", cyc, e.c);
      end
    end
    prev_gnt = gnt;
    if (done != 4'b0) begin
      if (dq.size() == 0) cmp("unexpected_done", 32'(done), 0);
      else begin
        e = dq.pop_front();
        cmp("done_value", 32'(done), 32'(e.v));
        cmp("done_cycle", cyc, e.c);
        cmp("done_count", 32'(count_out), e.cnt);
        cmp("done_in_gnt", 32'(done & ~gnt), 0);
        cmp("gnt_onehot", $countones(gnt), 1);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    tick = 1'b1;
    step();
    step();
    cmp("rst_gnt", 32'(gnt), 0);
    cmp("rst_done", 32'(done), 0);
    cmp("rst_busy", 32'(busy), 0);
    cmp("rst_count", 32'(count_out), 0);
    rst = 1'b0;
    // reset in the middle of a run, then priority restarts at requester 0
    dur[15:8] = 8'd10;
    req = 4'b0010;
    e = cyc + 1;
    push_g(1, e);
    wait_cyc(e + 4);
    cmp("run_count4", 32'(count_out), 4);
    rst = 1'b1;
    step();
    cmp("midrst_gnt", 32'(gnt), 0);
    cmp("midrst_busy", 32'(busy), 0);
    cmp("midrst_count", 32'(count_out), 0);
    rst = 1'b0;
    dur[7:0] = 8'd3;
    req = 4'b0011;
    e = cyc + 1;
    push_g(0, e);
    push_d(0, e + 4, 3);
    push_g(1, e + 6);
    push_d(1, e + 17, 10);
    wait_cyc(e + 4);
    req = 4'b0010;
    wait_cyc(e + 17);
    req = 4'b0;
    step();
    step();
    // basic timing
    dur[23:16] = 8'd5;
    req = 4'b0100;
    e = cyc + 1;
    push_g(2, e);
    push_d(2, e + 6, 5);
    for (int k = 0; k <= 5; k++) begin
      wait_cyc(e + k);
      cmp("basic_count", 32'(count_out), k);
    end
    wait_cyc(e + 6);
    req = 4'b0;
    step();
    cmp("basic_gnt_clear", 32'(gnt), 0);
    cmp("basic_busy_clear", 32'(busy), 0);
    // tick gating: one tick every 4 cycles
    tick = 1'b0;
    dur[7:0] = 8'd3;
    req = 4'b0001;
    e = cyc + 1;
    push_g(0, e);
    push_d(0, e + 13, 3);
    for (int t = e; t <= e + 13; t++) begin
      wait_cyc(t);
      cmp("gate_count", 32'(count_out), ((t - e) / 4 > 3) ? 3 : (t - e) / 4);
      tick = ((t - e) % 4 == 3);
    end
    req = 4'b0;
    tick = 1'b1;
    step();
    step();
    // round robin with all requesters held
    rst = 1'b1;
    step();
    rst = 1'b0;
    dur = {8'd2, 8'd2, 8'd2, 8'd2};
    req = 4'b1111;
    e = cyc + 1;
    for (int k = 0; k < 5; k++) begin
      push_g(k % 4, e + 5 * k);
      push_d(k % 4, e + 3 + 5 * k, 2);
    end
    wait_cyc(e + 23);
    req = 4'b0;
    step();
    step();
    // abort at count 3
    dur[15:8] = 8'd8;
    req = 4'b0010;
    e = cyc + 1;
    push_g(1, e);
    wait_cyc(e + 3);
    cmp("abort_count3", 32'(count_out), 3);
    abort = 1'b1;
    step();
    cmp("abort_gnt", 32'(gnt), 0);
    cmp("abort_busy", 32'(busy), 0);
    cmp("abort_count", 32'(count_out), 0);
    abort = 1'b0;
    req = 4'b0;
    step();
    step();
    cmp("abort_idle", 32'(busy), 0);
    // owner drops req at count 3
    req = 4'b0010;
    e = cyc + 1;
    push_g(1, e);
    wait_cyc(e + 3);
    req = 4'b0;
    step();
    cmp("drop_gnt", 32'(gnt), 0);
    cmp("drop_busy", 32'(busy), 0);
    cmp("drop_count", 32'(count_out), 0);
    step();
    // abort while in DONE
    req = 4'b0010;
    e = cyc + 1;
    push_g(1, e);
    push_d(1, e + 9, 8);
    wait_cyc(e + 9);
    abort = 1'b1;
    req = 4'b0;
    step();
    cmp("abort_done_gnt", 32'(gnt), 0);
    cmp("abort_done_busy", 32'(busy), 0);
    abort = 1'b0;
    step();
    // zero duration
    dur[7:0] = 8'd0;
    req = 4'b0001;
    e = cyc + 1;
    push_g(0, e);
    push_d(0, e + 1, 0);
    wait_cyc(e + 1);
    req = 4'b0;
    step();
    step();
    // maximum duration saturates without wrapping
    dur[23:16] = 8'hFF;
    req = 4'b0100;
    e = cyc + 1;
    push_g(2, e);
    push_d(2, e + 256, 255);
    wait_cyc(e + 255);
    cmp("ff_count_at_max", 32'(count_out), 255);
    wait_cyc(e + 256);
    cmp("ff_count_in_done", 32'(count_out), 255);
    req = 4'b0;
    step();
    cmp("ff_count_clear", 32'(count_out), 0);
    cmp("ff_gnt_clear", 32'(gnt), 0);
    step();
    // duration change after grant is ignored
    dur[31:24] = 8'd4;
    req = 4'b1000;
    e = cyc + 1;
    push_g(3, e);
    push_d(3, e + 5, 4);
    wait_cyc(e + 2);
    dur[31:24] = 8'd20;
    wait_cyc(e + 5);
    req = 4'b0;
    step();
    step();
    step();
    cmp("gq_drained", gq.size(), 0);
    cmp("dq_drained", dq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
